// File: rtl/mult_datapath.sv
// Operand/accumulator datapath for a sequential MSB-first shift-add multiplier.
// Holds multiplicand, multiplier shift register and 2W accumulator; captures results and flags strobe misuse.
module mult_datapath #(
    parameter int unsigned W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    shift,
    input  logic                    add,
    input  logic                    ready,
    input  logic [W-1:0]            multiplicand,
    input  logic [W-1:0]            multiplier,
    output logic                    msb_multiplier,
    output logic [2*W-1:0]          product,
    output logic                    product_valid,
    output logic                    busy,
    output logic [$clog2(W+1)-1:0]  iter_count,
    output logic                    proto_err
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned PW = 2 * W;

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  m_q, m_d;
    logic [PW-1:0] p_q, p_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] product_q, product_d;
    logic          product_valid_q, product_valid_d;
    logic          proto_err_q, proto_err_d;
    logic          capture;
    logic          iter_full;

    assign msb_multiplier = m_q[W-1];
    assign product        = product_q;
    assign product_valid  = product_valid_q;
    assign busy           = busy_q;
    assign iter_count     = iter_q;
    assign proto_err      = proto_err_q;

    assign capture   = ready && !ready_q && busy_q;
    assign iter_full = (iter_q == CW'(W));

    // Capture is evaluated first so a same-edge init still sees the old P and re-arms busy.
    always_comb begin
        a_d             = a_q;
        m_d             = m_q;
        p_d             = p_q;
        ready_d         = ready;
        iter_d          = iter_q;
        busy_d          = busy_q;
        product_d       = product_q;
        product_valid_d = 1'b0;
        proto_err_d     = proto_err_q;

        if (capture) begin
            product_d       = p_q;
            product_valid_d = 1'b1;
            busy_d          = 1'b0;
            if (!iter_full) begin
                proto_err_d = 1'b1;
            end
        end

        if (init) begin
            a_d    = multiplicand;
            m_d    = multiplier;
            p_d    = '0;
            iter_d = '0;
            busy_d = 1'b1;
            if (shift || add) begin
                proto_err_d = 1'b1;
            end
        end else if (shift) begin
            p_d = PW'(p_q << 1) + (add ? {{W{1'b0}}, a_q} : {PW{1'b0}});
            m_d = {m_q[W-2:0], 1'b0};
            if (iter_full) begin
                proto_err_d = 1'b1;
            end else begin
                iter_d = iter_q + CW'(1);
            end
            if (!busy_q) begin
                proto_err_d = 1'b1;
            end
        end else if (add) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q             <= '0;
            m_q             <= '0;
            p_q             <= '0;
            ready_q         <= 1'b1;
            iter_q          <= '0;
            busy_q          <= 1'b0;
            product_q       <= '0;
            product_valid_q <= 1'b0;
            proto_err_q     <= 1'b0;
        end else begin
            a_q             <= a_d;
            m_q             <= m_d;
            p_q             <= p_d;
            ready_q         <= ready_d;
            iter_q          <= iter_d;
            busy_q          <= busy_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
            proto_err_q     <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: drives controller strobes, checks products and status flags.
module tb_mult_datapath;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic         shift;
    logic         add;
    logic         ready;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         msb_multiplier;
    logic [15:0]  product;
    logic         product_valid;
    logic         busy;
    logic [3:0]   iter_count;
    logic         proto_err;

    int           errors = 0;
    int           checks = 0;
    logic [15:0]  exp_q[$];
    logic         pv_prev = 1'b0;

    mult_datapath #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .init           (init),
        .shift          (shift),
        .add            (add),
        .ready          (ready),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .msb_multiplier (msb_multiplier),
        .product        (product),
        .product_valid  (product_valid),
        .busy           (busy),
        .iter_count     (iter_count),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pops the scoreboard whenever a product is presented.
    always @(negedge clk) begin
        if (!rst && product_valid) begin
            check("pv_two_cycles", 32'(pv_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(product_valid), 32'd0);
            end else begin
                check("product", 32'(product), 32'(exp_q.pop_front()));
            end
        end
        pv_prev = product_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ready = 1'b1;
        init = 1'b0;
        shift = 1'b0;
        add = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        init = 1'b1;
        ready = 1'b0;
        multiplicand = a;
        multiplier = b;
        tick();
        init = 1'b0;
        check("busy_after_init", 32'(busy), 32'd1);
        check("iter_after_init", 32'(iter_count), 32'd0);
    endtask

    task automatic do_shifts(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            check("msb", 32'(msb_multiplier), 32'(b[7-i]));
            ready = 1'b0;
            shift = 1'b1;
            add = msb_multiplier;
            tick();
            shift = 1'b0;
            add = 1'b0;
        end
    endtask

    task automatic finish_op(input logic [15:0] exp);
        ready = 1'b1;
        exp_q.push_back(exp);
        tick();
        check("pv_pulse", 32'(product_valid), 32'd1);
        check("busy_after_capture", 32'(busy), 32'd0);
        tick();
        check("pv_low_after", 32'(product_valid), 32'd0);
    endtask

    initial begin
        multiplicand = '0;
        multiplier = '0;
        do_reset();
        check("rst_product", 32'(product), 32'd0);
        check("rst_pv", 32'(product_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        check("rst_msb", 32'(msb_multiplier), 32'd0);
        tick();
        check("no_valid_after_rst", 32'(product_valid), 32'd0);

        // 0x0D * 0x0B
        load(8'h0D, 8'h0B);
        do_shifts(8'h0B, 8);
        check("iter_8", 32'(iter_count), 32'd8);
        finish_op(16'h008F);
        check("err_clean_1", 32'(proto_err), 32'd0);

        // 0xFF * 0xFF
        load(8'hFF, 8'hFF);
        do_shifts(8'hFF, 8);
        check("iter_8_ff", 32'(iter_count), 32'd8);
        finish_op(16'hFE01);

        // zero operands
        load(8'h00, 8'hA5);
        do_shifts(8'hA5, 8);
        finish_op(16'h0000);
        load(8'h37, 8'h00);
        do_shifts(8'h00, 8);
        finish_op(16'h0000);
        check("err_clean_2", 32'(proto_err), 32'd0);

        // back-to-back: init in the ready-rise cycle
        load(8'h02, 8'h04);
        do_shifts(8'h04, 8);
        ready = 1'b1;
        init = 1'b1;
        multiplicand = 8'h03;
        multiplier = 8'h05;
        exp_q.push_back(16'h0008);
        tick();
        init = 1'b0;
        check("b2b_pv", 32'(product_valid), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_iter", 32'(iter_count), 32'd0);
        do_shifts(8'h05, 8);
        finish_op(16'h000F);
        check("err_clean_3", 32'(proto_err), 32'd0);

        // reset mid-operation
        load(8'h0D, 8'h0B);
        do_shifts(8'h0B, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_iter", 32'(iter_count), 32'd0);
        check("midrst_pv", 32'(product_valid), 32'd0);
        ready = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        check("midrst_no_pv", 32'(product_valid), 32'd0);
        check("midrst_product2", 32'(product), 32'd0);
        check("midrst_busy2", 32'(busy), 32'd0);

        // add without shift leaves P alone but sets the sticky flag
        load(8'h05, 8'h03);
        do_shifts(8'h03, 2);
        add = 1'b1;
        tick();
        add = 1'b0;
        check("add_noshift_err", 32'(proto_err), 32'd1);
        check("add_noshift_iter", 32'(iter_count), 32'd2);
        do_shifts(8'h03, 0);
        for (int i = 2; i < 8; i++) begin
            shift = 1'b1;
            add = msb_multiplier;
            tick();
            shift = 1'b0;
            add = 1'b0;
        end
        finish_op(16'h000F);
        check("add_noshift_sticky", 32'(proto_err), 32'd1);
        do_reset();
        check("err_cleared", 32'(proto_err), 32'd0);

        // early ready after 7 shifts: 0x0D * 0b0000101 = 0x41
        load(8'h0D, 8'h0B);
        do_shifts(8'h0B, 7);
        check("iter_7", 32'(iter_count), 32'd7);
        finish_op(16'h0041);
        check("early_err", 32'(proto_err), 32'd1);
        load(8'h03, 8'h03);
        do_shifts(8'h03, 8);
        finish_op(16'h0009);
        check("early_err_sticky", 32'(proto_err), 32'd1);
        do_reset();
        check("err_cleared_2", 32'(proto_err), 32'd0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Operand/accumulator datapath for the sequential shift-add multiplier. It is driven by the multiplier controller's `init`/`shift`/`add`/`ready` strobes and returns `msb_multiplier` to it. Internally it holds the multiplicand, the multiplier shift register and the 2W-bit accumulator. It also captures the finished product behind a one-cycle valid pulse and flags strobe-protocol violations for the verification environment.

## Interface
- `W`, default 8, operand width in bits; product width is 2W.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset. Synchronous, active-high, sampled on the rising edge of `clk`.
- `init`  input  1  load operands and clear the accumulator (from controller).
- `shift`  input  1  perform one iteration (from controller).
- `add`  input  1  add the multiplicand in this iteration; valid only with `shift`.
- `ready`  input  1  controller idle indicator; its rising edge marks end of operation.
- `multiplicand`  input  W  operand A, sampled when `init`=1.
- `multiplier`  input  W  operand B, sampled when `init`=1.
- `msb_multiplier`  output  1  combinational, equals M[W-1] of the multiplier shift register.
- `product`  output  2W  last captured result, held until the next capture.
- `product_valid`  output  1  one-cycle pulse when `product` updates.
- `busy`  output  1  an operation is loaded and not yet captured.
- `iter_count`  output  clog2(W+1)  shift strobes accepted since the last `init`, saturating at W.
- `proto_err`  output  1  sticky protocol-violation flag, cleared only by `rst`.

## Operation
Registers: A (W), M (W), P (2W), ready_q, iter_count, busy, product, product_valid, proto_err.

**Reset**
- A=0, M=0, P=0, product=0, product_valid=0, busy=0, iter_count=0, proto_err=0.
- ready_q=1, so the controller's post-reset `ready`=1 is not seen as a rising edge.

**Init** (`init`=1)
- A<=multiplicand, M<=multiplier, P<=0, iter_count<=0, busy<=1.
- `shift`/`add` in the same cycle are ignored, and proto_err<=1 if either is high.

**Iteration** (`shift`=1, `init`=0)
- MSB-first update: P <= (P<<1) + (add ? {W'b0,A} : 0), M <= M<<1 with zero fill.
- Result is truncated to 2W bits. No overflow is possible when exactly W iterations are run.
- iter_count increments, saturating at W.
- If iter_count==W before the strobe, set proto_err; the iteration is still performed.
- If busy=0, set proto_err; the iteration is still performed.

**Illegal add** (`add`=1, `shift`=0)
- Ignored for P and M; set proto_err.

**Capture**
- Condition: ready=1 and ready_q=0 and busy=1 at the edge.
- Effect: product<=P (value before this edge's update), product_valid<=1, busy<=0.
- If iter_count != W, also set proto_err; the product is still captured.
- A ready rising edge with busy=0 does nothing.

**Simultaneous capture and init** (back-to-back start)
- Capture uses the old P, then init loads new operands.
- busy ends the edge at 1 and product_valid pulses.

ready_q<=ready on every non-reset edge.

## Timing
- `msb_multiplier` is combinational from M, so it is valid in the same cycle the controller decides `add`.
- Init to first usable msb: 1 cycle (M is loaded at the edge that samples `init`).
- Each `shift` strobe updates P/M at that edge. W strobes give P = A*B.
- product/product_valid appear the cycle after the edge that samples ready's rising edge.
- product_valid is high for exactly one cycle per capture, never two consecutive cycles.
- Reset mid-operation:
  - Next cycle all outputs are at reset values and busy=0.
  - A following ready rise with no new `init` produces no product_valid.
- Strobe gaps (`shift` low between iterations) are legal and leave P/M unchanged.

## Test plan
- W=8, A=0x0D, B=0x0B:
  - Stimulus: init, then 8 shift strobes with add=msb_multiplier, then ready 0->1.
  - Response: product=0x008F, product_valid pulses 1 cycle, busy=0, proto_err=0.
- A=0xFF, B=0xFF, same sequence:
  - Response: product=0xFE01, iter_count=8, msb_multiplier sequence all ones.
- A=0x00, B=0xA5, then A=0x37, B=0x00:
  - Response: product=0x0000 both times, and msb sequence for B=0xA5 is 1,0,1,0,0,1,0,1.
- Back-to-back operations:
  - Stimulus: init with A=0x03, B=0x05 asserted in the ready-rise cycle of a prior 0x02*0x04 operation.
  - Response: product=0x0008 with pulse; then the second run gives product=0x000F.
- Reset mid-operation:
  - Stimulus: rst after 3 shifts, then ready rises with no init.
  - Response: no product_valid, product=0, busy=0.
- Protocol errors:
  - add without shift -> proto_err=1 and P unchanged.
  - Separately, ready rise after 7 shifts -> product captured and proto_err=1.
  - In both cases proto_err stays 1 until rst.
